// File: rtl/mdu_issue_ctrl_if.sv
// Handshake bundle between the ID/EX stage, the MDU and the hazard unit.
// The controller sits on the slave side; the pipeline side drives the ex_* fields.
interface mdu_issue_ctrl_if;
    logic       ex_valid;
    logic       ex_flush;
    logic [3:0] ex_mdu_op;
    logic       ex_rt_zero;

    logic       mdu_start;
    logic [1:0] mdu_op;
    logic       mdu_madd;
    logic       mdu_we;
    logic       mdu_hilo;
    logic       rd_en;
    logic       stall;
    logic       busy;
    logic       busy_div;
    logic       div_zero;
    logic       illegal;

    modport master (
        output ex_valid, ex_flush, ex_mdu_op, ex_rt_zero,
        input  mdu_start, mdu_op, mdu_madd, mdu_we, mdu_hilo, rd_en,
               stall, busy, busy_div, div_zero, illegal
    );

    modport slave (
        input  ex_valid, ex_flush, ex_mdu_op, ex_rt_zero,
        output mdu_start, mdu_op, mdu_madd, mdu_we, mdu_hilo, rd_en,
               stall, busy, busy_div, div_zero, illegal
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// EX-stage sequencer for the multiply/divide unit: decodes the MDU op class,
// drives the MDU strobes and stalls the pipeline while the unit is counting down.
module mdu_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    mdu_issue_ctrl_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;
    localparam logic [3:0] OP_MFHI  = 4'd8;
    localparam logic [3:0] OP_MFLO  = 4'd9;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_div_zero;
    logic               r_illegal;

    logic               w_busy;
    logic               w_live;
    logic               w_is_mdu;
    logic               w_is_illegal;
    logic               w_req;
    logic               w_accept;
    logic               w_mul_issue;
    logic               w_div_issue;

    logic               w_start;
    logic [1:0]         w_op;
    logic               w_madd;
    logic               w_we;
    logic               w_hilo;
    logic               w_rd_en;

    assign w_busy       = (r_state != IDLE);
    // Gating with rst keeps every combinational strobe quiet while reset is held.
    assign w_live       = bus.ex_valid & ~bus.ex_flush & rst;
    assign w_is_mdu     = (bus.ex_mdu_op >= OP_MULT) && (bus.ex_mdu_op <= OP_MFLO);
    assign w_is_illegal = (bus.ex_mdu_op > OP_MFLO);
    assign w_req        = w_live & w_is_mdu;
    assign w_accept     = w_req & ~w_busy;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_start     = 1'b0;
        w_op        = 2'b00;
        w_madd      = 1'b0;
        w_we        = 1'b0;
        w_hilo      = 1'b0;
        w_rd_en     = 1'b0;
        w_mul_issue = 1'b0;
        w_div_issue = 1'b0;
        if (w_accept) begin
            case (bus.ex_mdu_op)
                OP_MULT:  begin w_start = 1'b1; w_op = 2'b01; w_mul_issue = 1'b1; end
                OP_MULTU: begin w_start = 1'b1; w_op = 2'b00; w_mul_issue = 1'b1; end
                OP_DIV:   begin w_start = 1'b1; w_op = 2'b11; w_div_issue = 1'b1; end
                OP_DIVU:  begin w_start = 1'b1; w_op = 2'b10; w_div_issue = 1'b1; end
                OP_MADD:  begin
                    w_start     = 1'b1;
                    w_madd      = 1'b1;
                    w_op        = 2'b01;
                    w_mul_issue = 1'b1;
                end
                OP_MTHI:  begin w_we    = 1'b1; w_hilo = 1'b0; end
                OP_MTLO:  begin w_we    = 1'b1; w_hilo = 1'b1; end
                OP_MFHI:  begin w_rd_en = 1'b1; w_hilo = 1'b0; end
                OP_MFLO:  begin w_rd_en = 1'b1; w_hilo = 1'b1; end
                default:  ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_div_zero <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_illegal <= w_live & w_is_illegal;
            if (w_div_issue) begin
                r_state    <= DBUSY;
                r_cnt      <= CNT_W'(DIV_LAT);
                r_div_zero <= bus.ex_rt_zero;
            end else if (w_mul_issue) begin
                r_state <= MBUSY;
                r_cnt   <= CNT_W'(MUL_LAT);
            end else if (w_busy) begin
                // Flushes and idle cycles never interrupt an in-flight operation.
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_state <= IDLE;
                end
            end
        end
    end

    assign bus.mdu_start = w_start;
    assign bus.mdu_op    = w_op;
    assign bus.mdu_madd  = w_madd;
    assign bus.mdu_we    = w_we;
    assign bus.mdu_hilo  = w_hilo;
    assign bus.rd_en     = w_rd_en;
    assign bus.stall     = w_req & w_busy;
    assign bus.busy      = w_busy;
    assign bus.busy_div  = (r_state == DBUSY);
    assign bus.div_zero  = r_div_zero;
    assign bus.illegal   = r_illegal;

endmodule
